// File: rtl/counter_sched_pkg.sv
// rtl/counter_sched_pkg.sv - shared state type, default width and pointer helper for counter_sched
package counter_sched_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} sched_state_t;

    localparam int CNT_W_DEF = 4;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// rtl/counter_sched_rr_arbiter.sv - rotating-start request arbiter (COUNTER_SCHED_FIXED_PRIO_EN: lowest index wins)
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] pointer,
    output logic [NUM_REQ-1:0]         winner,
    output logic [$clog2(NUM_REQ)-1:0] winner_idx
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] base;
    logic             found;
    int               j;

`ifdef COUNTER_SCHED_FIXED_PRIO_EN
    logic unused_pointer;
    assign unused_pointer = ^pointer;
    assign base = '0;
`else
    assign base = pointer;
`endif

    // Scan upward from base, wrapping; the first active request wins.
    always_comb begin
        found      = 1'b0;
        winner_idx = '0;
        j          = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(base) + i) % NUM_REQ;
            if (!found && req[j]) begin
                found      = 1'b1;
                winner_idx = PTR_W'(j);
            end
        end
        winner = found ? (NUM_REQ'(1) << winner_idx) : '0;
    end

endmodule

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - shares one enable counter among requesters for timed intervals (COUNTER_SCHED_FIXED_PRIO_EN selects fixed priority)
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] len,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     cnt_en,
    output logic                     cnt_clr,
    input  logic [CNT_W-1:0]         cnt_count
);

    localparam int PTR_W = $clog2(NUM_REQ);

    sched_state_t       state;
    logic [NUM_REQ-1:0] grant_q;
    logic [PTR_W-1:0]   owner_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_next;
    logic [CNT_W-1:0]   len_q;
    logic [NUM_REQ-1:0] win;
    logic [PTR_W-1:0]   win_idx;
    logic [CNT_W-1:0]   len_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
        assign len_arr[g] = len[g*CNT_W +: CNT_W];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req),
        .pointer    (ptr_q),
        .winner     (win),
        .winner_idx (win_idx)
    );

`ifdef COUNTER_SCHED_FIXED_PRIO_EN
    assign ptr_next = '0;
`else
    assign ptr_next = PTR_W'(wrap_inc(int'(owner_q), NUM_REQ));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            len_q   <= '0;
            ptr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_q <= win;
                        owner_q <= win_idx;
                        len_q   <= len_arr[win_idx];
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (!req[owner_q]) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_next;
                        state   <= IDLE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // An owner drop outranks reaching the target count.
                    if (!req[owner_q]) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_next;
                        state   <= IDLE;
                    end else if (cnt_count == len_q) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    grant_q <= '0;
                    ptr_q   <= ptr_next;
                    state   <= IDLE;
                end
                default: begin
                    grant_q <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign done    = (state == DONE) ? grant_q : '0;
    assign busy    = (state != IDLE);
    assign cnt_clr = (state == CLEAR);
    // Combinational so an abort or the final count stops the counter in the same cycle.
    assign cnt_en  = (state == RUN) && req[owner_q] && (cnt_count != len_q);

endmodule

// File: tb/tb_counter_sched.sv
// tb/tb_counter_sched.sv - randomized and directed checks of counter_sched against an elapsed-cycle job model
`timescale 1ns/1ps
module tb_counter_sched;

    localparam int N  = 4;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*CW-1:0] len_v = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;
    logic            cnt_en;
    logic            cnt_clr;
    logic [CW-1:0]   cnt_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    counter_sched #(.NUM_REQ(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .len       (len_v),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .cnt_count (cnt_count)
    );

    // The shared counter the scheduler drives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         cnt_count <= '0;
        else if (cnt_clr) cnt_count <= '0;
        else if (cnt_en)  cnt_count <= cnt_count + 1'b1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Job model: a job is its owner, its length and the cycles elapsed since grant.
    // k=1 clear, k=2..2+len run, k=3+len done pulse.
    bit m_active = 1'b0;
    int m_k = 0;
    int m_len = 0;
    int m_owner = 0;
    int m_ptr = 0;
    int start;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 1'b0;
            m_ptr    = 0;
        end else if (!m_active) begin
            if (req != 0) begin
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
                start = 0;
`else
                start = m_ptr;
`endif
                for (int i = 0; i < N; i++) begin
                    if (!m_active && req[(start + i) % N]) begin
                        m_owner  = (start + i) % N;
                        m_active = 1'b1;
                    end
                end
                m_len = int'(len_v[m_owner*CW +: CW]);
                m_k   = 1;
            end
        end else if (m_k <= 2 + m_len && !req[m_owner]) begin
            m_active = 1'b0;
            m_ptr    = (m_owner + 1) % N;
        end else if (m_k == 3 + m_len) begin
            m_active = 1'b0;
            m_ptr    = (m_owner + 1) % N;
        end else begin
            m_k++;
        end
    end

    int  exp_g, exp_d;
    bit  exp_b, exp_e, exp_c;

    always @(negedge clk) begin
        exp_g = 0; exp_d = 0; exp_b = 0; exp_e = 0; exp_c = 0;
        if (m_active) begin
            exp_g = 1 << m_owner;
            exp_b = 1'b1;
            exp_c = (m_k == 1);
            exp_e = (m_k >= 2) && (m_k <= 2 + m_len) && req[m_owner] && (m_k - 2 != m_len);
            exp_d = (m_k == 3 + m_len) ? exp_g : 0;
        end
        chk("grant", int'(grant), exp_g);
        chk("done", int'(done), exp_d);
        chk("busy", int'(busy), int'(exp_b));
        chk("cnt_en", int'(cnt_en), int'(exp_e));
        chk("cnt_clr", int'(cnt_clr), int'(exp_c));
        if (m_active && m_k >= 2 && m_k <= 2 + m_len)
            chk("count", int'(cnt_count), m_k - 2);
        chk("grant_onehot0", int'((grant & (grant - 1'b1)) == 0), 1);
        chk("done_in_grant", int'((done & ~grant) == 0), 1);
        chk("en_clr_excl", int'(cnt_en && cnt_clr), 0);
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_reached", int'(busy), 0);
    endtask

    task automatic run_job(input int idx, input int l, input bit disturb);
        int t0, dcyc, ens, dcnt, dval;
        bit seen;
        @(posedge clk); #2;
        len_v[idx*CW +: CW] = CW'(l);
        req[idx] = 1'b1;
        t0 = cyc; seen = 0; ens = 0; dcyc = 0; dcnt = 0; dval = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (cnt_en) ens++;
            if (done != 0) begin
                seen = 1; dcyc = cyc; dval = int'(done); dcnt = int'(cnt_count);
            end else if (disturb && i >= 3) begin
                @(posedge clk); #2;
                len_v[idx*CW +: CW] = CW'($urandom);
                for (int j = 0; j < N; j++)
                    if (j != idx) req[j] = 1'($urandom);
            end
        end
        chk("job_done_seen", int'(seen), 1);
        chk("job_done_cycle", dcyc - t0, 3 + l);
        chk("job_done_owner", dval, 1 << idx);
        chk("job_en_cycles", ens, l);
        chk("job_count_at_done", dcnt, l);
        @(posedge clk); #2;
        req = '0;
        wait_idle();
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        int rr_exp [5];
        int g, seen_d, ndone, s, v, i;

        // Reset held with every request active.
        req   = '1;
        len_v = '1;
        repeat (3) @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_en", int'(cnt_en), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk); #2;
        req = '0;
        rst = 1'b1;

        run_job(2, 3, 1'b0);
        run_job(0, 0, 1'b0);
        run_job(1, 15, 1'b0);
        run_job(3, 4, 1'b1);

        // Arbitration order with everyone requesting.
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
        rr_exp = '{1, 1, 1, 1, 1};
`else
        rr_exp = '{1, 2, 4, 8, 1};
`endif
        do_reset();
        len_v = {N{4'd1}};
        @(posedge clk); #2;
        req = '1;
        for (int k = 0; k < 5; k++) begin
            g = 0;
            for (i = 0; i < 40; i++) begin
                @(negedge clk);
                if (cnt_clr) begin g = int'(grant); break; end
            end
            chk($sformatf("rr_order_%0d", k), g, rr_exp[k]);
        end
        @(posedge clk); #2;
        req = '0;
        wait_idle();

        // Abort two cycles into RUN; the next grant goes to requester 2.
        do_reset();
        len_v[1*CW +: CW] = 4'd8;
        @(posedge clk); #2;
        req = 4'b0110;
        repeat (4) @(posedge clk);
        #1 chk("run_en_before_abort", int'(cnt_en), 1);
        #1 req[1] = 1'b0;
        #1 chk("abort_en_drop", int'(cnt_en), 0);
        chk("abort_grant_held", int'(grant), 2);
        seen_d = 0; g = 0;
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done[1]) seen_d = 1;
            if (cnt_clr) begin g = int'(grant); break; end
        end
        chk("abort_no_done", seen_d, 0);
        chk("abort_next_grant", g, 4);
        @(posedge clk); #2;
        req = '0;
        wait_idle();

        // Asynchronous reset in the middle of a run.
        len_v[0 +: CW] = 4'd8;
        @(posedge clk); #2;
        req[0] = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("midrst_grant", int'(grant), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_en", int'(cnt_en), 0);
        chk("midrst_done", int'(done), 0);
        req = '0;
        @(posedge clk); #2;
        rst = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done != 0) ndone++;
        end
        chk("midrst_no_done", ndone, 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            for (int r = 0; r < N; r++) begin
                if (m_active && r == m_owner) begin
                    if ($urandom_range(0, 99) < 3) req[r] = 1'b0;
                end else if ($urandom_range(0, 99) < 25) begin
                    req[r] = ~req[r];
                end
            end
            if ($urandom_range(0, 9) == 0) begin
                s = $urandom_range(0, N - 1);
                case ($urandom_range(0, 3))
                    0:       v = 0;
                    1:       v = 15;
                    default: v = $urandom_range(0, 6);
                endcase
                len_v[s*CW +: CW] = CW'(v);
            end
        end
        @(posedge clk); #2;
        req = '0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
